// File: rtl/uart_tx_buffered_if.sv
// Host write port of the buffered UART transmitter: push strobe, data and FIFO status.
interface uart_tx_buffered_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic [LEVEL_W-1:0]    level;
    logic                  overflow;

    modport master (output wr_en, wr_data, input full, empty, level, overflow);
    modport slave  (input wr_en, wr_data, output full, empty, level, overflow);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: synchronous FIFO, baud tick generator and framing FSM
// with optional parity, 1/2 stop bits and zero-gap back-to-back frames.
module uart_tx_buffered #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_mode,
    input  logic                 stop2,
    uart_tx_buffered_if.slave    wr_port,
    output logic                 busy,
    output logic                 tx,
    output logic                 tx_done
);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;
    localparam int unsigned SAMP_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state;
    logic [DIV_WIDTH-1:0]  tick_cnt;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [SAMP_W-1:0]     samp_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LEVEL_W-1:0]    level_nxt_c;
    logic [DATA_WIDTH-1:0] head_c;

    logic tick_c;
    logic bit_end_c;
    logic frame_end_c;
    logic pop_c;
    logic push_c;

    // Divisor is re-sampled only at a wrap so a change never shortens a running period.
    assign tick_c = (tick_cnt == div_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            div_q    <= baud_div;
        end else if (tick_c) begin
            tick_cnt <= '0;
            div_q    <= baud_div;
        end else begin
            tick_cnt <= tick_cnt + DIV_WIDTH'(1);
        end
    end

    assign bit_end_c   = tick_c && (samp_cnt == SAMP_W'(OVERSAMPLE - 1));
    assign frame_end_c = bit_end_c && (state == S_STOP) && (!stop2_q || stop_cnt);
    assign pop_c       = !wr_port.empty && (((state == S_IDLE) && tick_c) || frame_end_c);
    assign push_c      = wr_port.wr_en && (!wr_port.full || pop_c);
    assign head_c      = mem[rd_ptr];

    always_comb begin
        level_nxt_c = wr_port.level;
        if (push_c && !pop_c) begin
            level_nxt_c = wr_port.level + LEVEL_W'(1);
        end else if (pop_c && !push_c) begin
            level_nxt_c = wr_port.level - LEVEL_W'(1);
        end
    end

    // When full, a same-cycle pop and push share one slot: the head is read before the write lands.
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            mem[wr_ptr] <= wr_port.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            wr_port.level    <= '0;
            wr_port.full     <= 1'b0;
            wr_port.empty    <= 1'b1;
            wr_port.overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            wr_port.level    <= level_nxt_c;
            wr_port.full     <= (level_nxt_c == LEVEL_W'(FIFO_DEPTH));
            wr_port.empty    <= (level_nxt_c == '0);
            wr_port.overflow <= wr_port.wr_en && wr_port.full && !pop_c;
        end
    end

    // Framing FSM; a pop (from IDLE or at the end of the last stop bit) overrides the case below.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tick_c) begin
                samp_cnt <= bit_end_c ? '0 : samp_cnt + SAMP_W'(1);
            end
            case (state)
                S_IDLE: begin
                    samp_cnt <= '0;
                end
                S_START: begin
                    if (bit_end_c) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        tx      <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                            state    <= par_en_q ? S_PARITY : S_STOP;
                            tx       <= par_en_q ? par_bit_q : 1'b1;
                            stop_cnt <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            tx      <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        state    <= S_STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (frame_end_c) begin
                        state   <= S_IDLE;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                    end else if (bit_end_c) begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
            if (pop_c) begin
                shift_q   <= head_c;
                par_en_q  <= parity_en;
                par_bit_q <= (^head_c) ^ parity_mode;
                stop2_q   <= stop2;
                samp_cnt  <= '0;
                state     <= S_START;
                tx        <= 1'b0;
                busy      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_buffered;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned OS    = 16;
    localparam int unsigned DIVW  = 11;
    localparam int          MAXC  = 8192;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [DIVW-1:0] baud_div = '0;
    logic            parity_en = 1'b0;
    logic            parity_mode = 1'b0;
    logic            stop2 = 1'b0;
    logic            busy;
    logic            tx;
    logic            tx_done;

    always #5 clk = ~clk;

    uart_tx_buffered_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) wr_port ();

    uart_tx_buffered #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .DIV_WIDTH(DIVW)
    ) dut (
        .clk(clk), .reset(reset), .baud_div(baud_div), .parity_en(parity_en),
        .parity_mode(parity_mode), .stop2(stop2), .wr_port(wr_port),
        .busy(busy), .tx(tx), .tx_done(tx_done)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame = list of line bits, position = ticks elapsed since frame start.
    int            m_e;
    int            m_div;
    logic [DW-1:0] m_q[$];
    bit            m_active;
    bit            m_bits[16];
    int            m_len;
    int            m_ticks;
    logic          e_tx, e_busy, e_done, e_ovf;
    int            e_level;
    logic          tx_hist [MAXC];
    int            done_q[$];
    int            ovf_pulses = 0;

    function automatic void start_frame(input logic [DW-1:0] d);
        m_len = 0;
        m_bits[m_len] = 1'b0; m_len++;
        for (int i = 0; i < int'(DW); i++) begin
            m_bits[m_len] = d[i]; m_len++;
        end
        if (parity_en) begin
            m_bits[m_len] = (^d) ^ parity_mode; m_len++;
        end
        m_bits[m_len] = 1'b1; m_len++;
        if (stop2) begin
            m_bits[m_len] = 1'b1; m_len++;
        end
        m_active = 1'b1;
        m_ticks  = 0;
    endfunction

    always @(posedge clk) begin
        bit tick;
        bit pop;
        int sz;
        cyc++;
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_e      = 0;
            m_div    = int'(baud_div);
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
        end else begin
            tick = ((m_e % (m_div + 1)) == m_div);
            m_e++;
            sz = m_q.size();
            pop = 1'b0;
            e_done = 1'b0;
            e_ovf = 1'b0;
            if (tick && m_active) begin
                m_ticks++;
                if (m_ticks == m_len * int'(OS)) begin
                    e_done = 1'b1;
                    m_active = 1'b0;
                    if (sz > 0) pop = 1'b1;
                end
            end else if (tick && !m_active && sz > 0) begin
                pop = 1'b1;
            end
            if (pop) start_frame(m_q.pop_front());
            if (wr_port.wr_en) begin
                if (sz < int'(DEPTH) || pop) m_q.push_back(wr_port.wr_data);
                else e_ovf = 1'b1;
            end
            e_tx   = m_active ? m_bits[m_ticks / int'(OS)] : 1'b1;
            e_busy = m_active;
        end
        e_level = m_q.size();
        #1;
        check("tx", tx, e_tx);
        check("busy", busy, e_busy);
        check("tx_done", tx_done, e_done);
        check("overflow", wr_port.overflow, e_ovf);
        check("level", wr_port.level, e_level);
        check("full", wr_port.full, (e_level == int'(DEPTH)));
        check("empty", wr_port.empty, (e_level == 0));
        if (cyc < MAXC) tx_hist[cyc] = tx;
        if (tx_done) done_q.push_back(cyc);
        if (wr_port.overflow) ovf_pulses++;
    end

    function automatic logic hist(input int i);
        if (i > 0 && i < MAXC && i <= cyc) return tx_hist[i];
        return 1'bx;
    endfunction

    function automatic int find_fall(input int from);
        for (int i = from + 1; i <= cyc && i < MAXC; i++) begin
            if (tx_hist[i] == 1'b0 && tx_hist[i-1] == 1'b1) return i;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] decode(input int n0);
        logic [DW-1:0] d;
        for (int i = 0; i < int'(DW); i++) d[i] = hist(n0 + int'(OS) * (1 + i) + 8);
        return d;
    endfunction

    task automatic do_reset(input int div);
        @(negedge clk);
        reset = 1'b1;
        baud_div = DIVW'(div);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write(input logic [DW-1:0] d);
        @(negedge clk);
        wr_port.wr_en = 1'b1;
        wr_port.wr_data = d;
    endtask

    task automatic stop_write();
        @(negedge clk);
        wr_port.wr_en = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, done_q.size() >= n, 1);
    endtask

    task automatic wait_fall(input int base, input int budget, output int n0);
        int k = 0;
        n0 = find_fall(base);
        while (n0 < 0 && k < budget) begin
            @(negedge clk);
            k++;
            n0 = find_fall(base);
        end
        check("frame_start_timeout", n0 >= 0, 1);
    endtask

    initial begin
        #(MAXC * 10 - 100);
        $display("FAIL watchdog: simulation did not finish within %0d cycles", MAXC - 10);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat1;
        int base, n0, n1, d0, ovf0, k;
        pat1 = 10'b1101001010;
        wr_port.wr_en = 1'b0;
        wr_port.wr_data = '0;

        // Reset state
        do_reset(0);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", wr_port.level, 0);
        check("rst_empty", wr_port.empty, 1);
        check("rst_full", wr_port.full, 0);

        // 1: 0xA5, no parity, 1 stop, tick every clk
        d0 = done_q.size(); base = cyc;
        write(8'hA5); stop_write();
        wait_done(d0 + 1, 400, "t1_done_timeout");
        n0 = find_fall(base);
        for (int i = 0; i < 10; i++) begin
            check("t1_bit_mid", hist(n0 + 16 * i + 8), pat1[i]);
            check("t1_bit_end", hist(n0 + 16 * i + 15), pat1[i]);
        end
        if (done_q.size() > d0) check("t1_frame_len", done_q[d0] - n0, 160);

        // 2: parity even then odd on 0xA5 (four ones)
        for (int m = 0; m < 2; m++) begin
            parity_en = 1'b1; parity_mode = m[0];
            d0 = done_q.size(); base = cyc;
            write(8'hA5); stop_write();
            wait_done(d0 + 1, 400, "t2_done_timeout");
            n0 = find_fall(base);
            check("t2_parity_bit", hist(n0 + 16 * 9 + 8), m[0]);
            check("t2_data", decode(n0), 8'hA5);
            if (done_q.size() > d0) check("t2_frame_len", done_q[d0] - n0, 176);
        end
        parity_en = 1'b0; parity_mode = 1'b0;

        // 3: two stop bits, divisor 3, back-to-back 0x00 then 0xFF
        stop2 = 1'b1;
        do_reset(3);
        d0 = done_q.size(); base = cyc;
        write(8'h00); write(8'hFF); stop_write();
        wait_done(d0 + 2, 2000, "t3_done_timeout");
        n0 = find_fall(base);
        if (done_q.size() > d0 + 1) begin
            check("t3_frame1_len", done_q[d0] - n0, 704);
            check("t3_done_spacing", done_q[d0+1] - done_q[d0], 704);
            check("t3_last_stop_high", hist(done_q[d0] - 1), 1);
            check("t3_no_gap_start", hist(done_q[d0]), 0);
        end
        stop2 = 1'b0;

        // 4: start stalled by the largest divisor; 17 writes overflow once
        do_reset(2047);
        ovf0 = ovf_pulses;
        for (int i = 0; i < 17; i++) write(DW'(8'h10 + i));
        stop_write();
        @(negedge clk);
        check("t4_level", wr_port.level, 16);
        check("t4_full", wr_port.full, 1);
        check("t4_overflow_pulses", ovf_pulses - ovf0, 1);
        k = 0;
        while ((m_e % 2048) != 2047 && k < 2100) begin
            @(negedge clk);
            k++;
        end
        wr_port.wr_en = 1'b1;
        wr_port.wr_data = 8'hEE;
        @(negedge clk);
        wr_port.wr_en = 1'b0;
        check("t4_pop_push_level", wr_port.level, 16);
        check("t4_pop_push_full", wr_port.full, 1);
        check("t4_pop_push_busy", busy, 1);
        check("t4_no_extra_overflow", ovf_pulses - ovf0, 1);

        // 5: reset in the middle of data bit 3
        do_reset(0);
        base = cyc;
        write(8'h5A); stop_write();
        wait_fall(base, 100, n0);
        k = 0;
        while (cyc < n0 + 69 && k < 200) begin
            @(negedge clk);
            k++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_tx_after_reset", tx, 1);
        check("t5_level_after_reset", wr_port.level, 0);
        check("t5_busy_after_reset", busy, 0);
        d0 = done_q.size();
        repeat (200) @(negedge clk);
        check("t5_no_tx_done", done_q.size(), d0);
        base = cyc;
        write(8'hC3); stop_write();
        wait_done(d0 + 1, 400, "t5_done_timeout");
        n1 = find_fall(base);
        check("t5_data_after_reset", decode(n1), 8'hC3);
        check("t5_stop_bit", hist(n1 + 16 * 9 + 8), 1);

        // 6: config change mid-frame only affects the following frame
        d0 = done_q.size(); base = cyc;
        write(8'h81); write(8'h7E); stop_write();
        repeat (50) @(negedge clk);
        parity_en = 1'b1; stop2 = 1'b1;
        wait_done(d0 + 2, 800, "t6_done_timeout");
        n0 = find_fall(base);
        check("t6_frame1_data", decode(n0), 8'h81);
        if (done_q.size() > d0 + 1) begin
            check("t6_frame1_len", done_q[d0] - n0, 160);
            check("t6_frame2_len", done_q[d0+1] - done_q[d0], 192);
            check("t6_frame2_data", decode(done_q[d0]), 8'h7E);
            check("t6_frame2_parity", hist(done_q[d0] + 16 * 9 + 8), 0);
        end
        parity_en = 1'b0; stop2 = 1'b0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
